// File: rtl/imem_multiport.sv
`default_nettype none
// ============================================================================
// Module   : imem_multiport
// Purpose  : Multi-slot instruction memory. Each request returns FETCH_WIDTH
//            consecutive words through a single-entry valid/ready response
//            register, with alignment/range checks, a program-load write
//            port and a flush input from the fetch redirect logic.
// Revision : 1.0  initial release
// ============================================================================
module imem_multiport #(
  parameter int IMEM_SIZE     = 16,
  parameter int IMEM_WORDSIZE = 32,
  parameter int FETCH_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [31:0]                          req_addr,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [31:0]                          rsp_addr,
  output logic [FETCH_WIDTH*IMEM_WORDSIZE-1:0] rsp_instr,
  output logic [FETCH_WIDTH-1:0]               rsp_slot_valid,
  output logic                                 rsp_fault,
  input  logic                                 flush,
  input  logic                                 wr_en,
  input  logic [31:0]                          wr_addr,
  input  logic [IMEM_WORDSIZE-1:0]             wr_data
);

  localparam int          c_aw   = (IMEM_SIZE > 1) ? $clog2(IMEM_SIZE) : 1;
  localparam logic [31:0] c_size = 32'(IMEM_SIZE);

  logic [IMEM_WORDSIZE-1:0] r_mem [IMEM_SIZE];

  logic [31:0]                          w_base;
  logic                                 w_fault;
  logic [FETCH_WIDTH-1:0]               w_slot_vld;
  logic [FETCH_WIDTH*IMEM_WORDSIZE-1:0] w_slot_data;
  logic [31:0]                          w_wr_idx;
  logic                                 w_wr_ok;
  logic                                 w_accept;

  logic                                 r_rsp_valid;
  logic [31:0]                          r_rsp_addr;
  logic [FETCH_WIDTH*IMEM_WORDSIZE-1:0] r_rsp_instr;
  logic [FETCH_WIDTH-1:0]               r_rsp_slot_valid;
  logic                                 r_rsp_fault;

  // Word index of slot 0; a fault suppresses every slot.
  assign w_base  = {2'b00, req_addr[31:2]};
  assign w_fault = (req_addr[1:0] != 2'b00) || (w_base >= c_size);

  // Per-slot range check and read; slots past the end read as zero (no wrap).
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
    logic [31:0] w_idx;
    assign w_idx          = w_base + 32'(gi);
    assign w_slot_vld[gi] = !w_fault && (w_idx < c_size);
    assign w_slot_data[gi*IMEM_WORDSIZE +: IMEM_WORDSIZE] =
      w_slot_vld[gi] ? r_mem[w_idx[c_aw-1:0]] : '0;
  end

  // Load port accepts only aligned, in-range word addresses.
  assign w_wr_idx = {2'b00, wr_addr[31:2]};
  assign w_wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (w_wr_idx < c_size);

  // Memory array: not reset; writes land after the read data is captured.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx[c_aw-1:0]] <= wr_data;
    end
  end

  assign req_ready = !flush && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  // Single-entry response register: reset > accept > flush/consume > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid      <= 1'b0;
      r_rsp_addr       <= '0;
      r_rsp_instr      <= '0;
      r_rsp_slot_valid <= '0;
      r_rsp_fault      <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid      <= 1'b1;
      r_rsp_addr       <= req_addr;
      r_rsp_instr      <= w_slot_data;
      r_rsp_slot_valid <= w_slot_vld;
      r_rsp_fault      <= w_fault;
    end else if (flush || (r_rsp_valid && rsp_ready)) begin
      r_rsp_valid      <= 1'b0;
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_addr       = r_rsp_addr;
  assign rsp_instr      = r_rsp_instr;
  assign rsp_slot_valid = r_rsp_slot_valid;
  assign rsp_fault      = r_rsp_fault;

endmodule
`default_nettype wire

// File: doc/imem_multiport.md
# imem_multiport

Parametrised instruction memory for the rv32 OoO front end. It returns FETCH_WIDTH consecutive 32-bit instruction words per request, through a registered valid/ready response stage with backpressure. It also checks alignment and range, provides a write port for program loading, and accepts a flush from the fetch redirect logic. It sits between the PC/fetch unit and the fetch queue/decoder, and generalises the two-port combinational imem to N slots with a handshake.

## Interface
- IMEM_SIZE, 16: memory depth in 32-bit words (≥ FETCH_WIDTH).
- IMEM_WORDSIZE, 32: instruction word width in bits.
- FETCH_WIDTH, 2: words returned per request (1..8).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request is accepted this cycle if also req_valid.
- req_addr  in  32  byte address of slot 0.
- rsp_valid  out  1  response held in output register.
- rsp_ready  in  1  consumer takes response this cycle.
- rsp_addr  out  32  req_addr of the captured request.
- rsp_instr  out  FETCH_WIDTH*IMEM_WORDSIZE  slot i in bits [i*W +: W].
- rsp_slot_valid  out  FETCH_WIDTH  slot i lies inside memory.
- rsp_fault  out  1  misaligned or base out of range.
- flush  in  1  discard held response; block acceptance this cycle.
- wr_en  in  1  load-port write strobe.
- wr_addr  in  32  byte address of write.
- wr_data  in  IMEM_WORDSIZE  write data.

## Operation
- Word index: base = req_addr[31:2]. Slot i reads mem[base+i].
- A slot is valid when base+i < IMEM_SIZE. Invalid slots return 0. There is no wrap-around.
- Misaligned request (req_addr[1:0] != 0) sets rsp_fault=1, all slot_valid=0, all instr=0.
- Base out of range (base ≥ IMEM_SIZE) sets rsp_fault=1, all slot_valid=0, all instr=0.
- A request with base in range, where only some slots fit, has rsp_fault=0 and partial slot_valid.
- Data is captured into the output register at the accept edge. Later writes never alter a held response.
- Output stage: single entry. req_ready = !flush && (!rsp_valid || rsp_ready). This gives full throughput when the consumer is always ready.
- Accept (req_valid && req_ready) loads the register and sets rsp_valid=1 on the next edge.
- Consume without a new accept: rsp_valid=0 on the next edge.
- Stall (rsp_valid && !rsp_ready): all rsp_* hold stable and req_ready=0.
- Flush: rsp_valid=0 on the next edge, regardless of rsp_ready. A request presented in the same cycle is not accepted.
- Write: on wr_en, mem[wr_addr[31:2]] = wr_data. The write is ignored if wr_addr[1:0] != 0 or the index ≥ IMEM_SIZE.
- Same-cycle write and accepted read of the same word: the read captures the old data (read-before-write).
- Memory contents are not affected by rst.

## Timing
- Reset values: rsp_valid=0, rsp_addr=0, rsp_instr=0, rsp_slot_valid=0, rsp_fault=0.
- req_ready is combinational. It is 1 in the first cycle after reset deassertion unless flush=1.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N, visible in cycle N+1.
- rst has priority over flush, accept and write.
  - rst during a stall drops the held response.
  - A write in a rst cycle is still performed. Only the response path is reset.
- Back-to-back: with rsp_ready=1 every cycle, one response per cycle with no bubbles.

## Test plan
- Load mem[k]=32'h1000_0000+k via the write port, k=0..15. Request addr 0x08, rsp_ready=1 → next cycle rsp_valid=1, instr slot0=0x10000002, slot1=0x10000003, slot_valid=2'b11, fault=0.
- Request 0x3C (word 15) → slot0=0x1000000F, slot1=0, slot_valid=2'b01, fault=0. Request 0x40 → fault=1, slot_valid=2'b00. Request 0x06 → fault=1.
- Accept 0x00, hold rsp_ready=0 for 3 cycles while writing mem[0]=0xDEADBEEF and presenting req 0x10:
  - rsp stays slot0=0x10000000 and req_ready=0 throughout.
  - Raising rsp_ready then accepts 0x10 the same cycle; the next response has addr 0x10.
- Stream 8 requests 0x00,0x08,…,0x38 with rsp_ready=1 → 8 consecutive responses, no gaps, in order.
- Assert flush while a response is held and req 0x20 is valid → rsp_valid=0 next cycle, 0x20 not accepted. Next cycle 0x20 is accepted normally.
- Assert rst while rsp_valid=1 and stalled → all rsp_* zero next cycle, req_ready=1. Memory still returns the loaded values afterwards.
